seq_det_1011: RTL and testbench



---
 rtl/seq_det_1011.sv | 125 ++++++++++++
 tb/tb_seq_det_1011.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/seq_det_1011.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// seq_det_1011
//
// Serial pattern detector for the bit sequence 1-0-1-1, with the first bit
// received first. It is a Moore FSM with a registered one-cycle detect pulse
// and a saturating count of detections. The design sits directly after the
// dff_asyn/dff_syn register stage, so din is already synchronous to clk and
// needs no synchroniser here.
//
// Build option:
//   SEQ_DET_OVERLAP_EN  defined   -> overlapping detection. An accepted 0 in S4
//                                    goes to S2.
//                       undefined -> non-overlapping detection. An accepted 0
//                                    in S4 goes to S0. This is the default.
//
// Parameters:
//   CNT_W      width of the detection counter, legal range 1..16 (default 8)
//
// Ports:
//   clk        system clock; all state changes on the rising edge
//   rst        asynchronous, active-high reset
//   din_valid  qualifies din; a bit is accepted only when this is 1
//   din        serial data bit from the upstream flip-flop
//   det        registered detect pulse, high for the cycle after the
//              accepted bit that completes 1011
//   det_cnt    number of detections since reset; saturates at 2^CNT_W-1
//   state_o    current FSM state encoding, for debug
// -----------------------------------------------------------------------------
module seq_det_1011 #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_valid,
    input  logic             din,
    output logic             det,
    output logic [CNT_W-1:0] det_cnt,
    output logic [2:0]       state_o
);

    // Each state is named after the prefix of 1011 matched so far.
    typedef enum logic [2:0] {
        S0 = 3'd0,  // nothing matched
        S1 = 3'd1,  // "1"
        S2 = 3'd2,  // "10"
        S3 = 3'd3,  // "101"
        S4 = 3'd4   // "1011", matched
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic             det_q, det_d;
    logic [CNT_W-1:0] det_cnt_q, det_cnt_d;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal written here gets a default before the case. Without
    // that, any path that leaves a signal unassigned infers a latch.
    always_comb begin
        state_d = state_q;

        case (state_q)
            S0: if (din_valid) state_d = din ? S1 : S0;
            S1: if (din_valid) state_d = din ? S1 : S2;
            S2: if (din_valid) state_d = din ? S3 : S0;
            S3: if (din_valid) state_d = din ? S4 : S2;
            S4: begin
                if (din_valid) begin
`ifdef SEQ_DET_OVERLAP_EN
                    // The trailing "1" of the match is reused as the
                    // start of the next "10".
                    state_d = din ? S1 : S2;
`else
                    state_d = din ? S1 : S0;
`endif
                end
            end
            // Codes 5..7 can only come from an upset. They recover to S0
            // whatever din_valid is.
            default: state_d = S0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Detect pulse and saturating counter
    // -------------------------------------------------------------------------
    // S4 is entered only through an accepted bit, and it is never re-entered
    // from itself. When the FSM sits in S4 with din_valid low, state_d is also
    // S4, and the din_valid term keeps det low in that case.
    always_comb begin
        det_d     = din_valid && (state_d == S4);
        det_cnt_d = det_cnt_q;
        if (det_d && (det_cnt_q != CNT_MAX)) begin
            det_cnt_d = det_cnt_q + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: the reset is in the sensitivity list, so it clears the outputs as
    // soon as rst rises and does not wait for a clock edge. A partial match,
    // a pending det pulse and the count are all discarded.
    // NOTE: state uses non-blocking assignments only. Blocking assignments
    // here would let later readers see the new value within the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S0;
            det_q     <= 1'b0;
            det_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            det_q     <= det_d;
            det_cnt_q <= det_cnt_d;
        end
    end

    assign det     = det_q;
    assign det_cnt = det_cnt_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_seq_det_1011.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_seq_det_1011
//
// Directed, self-checking bench for seq_det_1011. The main instance uses
// CNT_W=8. A second instance uses CNT_W=2, shares the same stimulus, and is
// used to exercise counter saturation. Expected values are written out by
// hand from the state table. The overlap expectations follow
// SEQ_DET_OVERLAP_EN.
// -----------------------------------------------------------------------------
module tb_seq_det_1011;

    logic       clk = 1'b0;
    logic       rst;
    logic       din_valid;
    logic       din;

    logic       det;
    logic [7:0] det_cnt;
    logic [2:0] state_o;

    logic       sat_det;
    logic [1:0] sat_cnt;
    logic [2:0] sat_state;

    int tests  = 0;
    int failed = 0;

    seq_det_1011 #(.CNT_W(8)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .din_valid (din_valid),
        .din       (din),
        .det       (det),
        .det_cnt   (det_cnt),
        .state_o   (state_o)
    );

    seq_det_1011 #(.CNT_W(2)) u_sat (
        .clk       (clk),
        .rst       (rst),
        .din_valid (din_valid),
        .din       (din),
        .det       (sat_det),
        .det_cnt   (sat_cnt),
        .state_o   (sat_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Checks state, det and det_cnt of the main instance.
    task automatic expect_main(input string tag, input int st, input int d, input int c);
        check({tag, ".state"}, 32'(state_o), 32'(st));
        check({tag, ".det"},   32'(det),     32'(d));
        check({tag, ".cnt"},   32'(det_cnt), 32'(c));
    endtask

    // Drives one cycle of input, then samples 1 ns after the rising edge.
    task automatic step(input logic v, input logic b);
        din_valid = v;
        din       = b;
        @(posedge clk);
        #1;
    endtask

    // Raises rst between clock edges and checks that the clear is immediate.
    // It releases rst just after the next edge, so the following step is the
    // first accepted edge.
    task automatic pulse_reset(input string tag);
        din_valid = 1'b0;
        din       = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        expect_main(tag, 0, 0, 0);
        check({tag, ".sat_cnt"}, 32'(sat_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin : stim
        logic [3:0] pat;
        int         path[10];
        logic [9:0] near;

        rst       = 1'b1;
        din_valid = 1'b0;
        din       = 1'b0;
        pat       = 4'b1011;

        // ---- Reset state ----
        #1;
        expect_main("reset", 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // ---- Basic detect: 1,0,1,1 ----
        step(1'b1, 1'b1); expect_main("basic1", 1, 0, 0);
        step(1'b1, 1'b0); expect_main("basic2", 2, 0, 0);
        step(1'b1, 1'b1); expect_main("basic3", 3, 0, 0);
        step(1'b1, 1'b1); expect_main("basic4", 4, 1, 1);
        step(1'b0, 1'b0); expect_main("basic_hold", 4, 0, 1);

        // ---- Overlap: 1,0,1,1,0,1,1 ----
        pulse_reset("ovl_rst");
        step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b1);
        step(1'b1, 1'b1); expect_main("ovl4", 4, 1, 1);
`ifdef SEQ_DET_OVERLAP_EN
        step(1'b1, 1'b0); expect_main("ovl5", 2, 0, 1);
        step(1'b1, 1'b1); expect_main("ovl6", 3, 0, 1);
        step(1'b1, 1'b1); expect_main("ovl7", 4, 1, 2);
`else
        step(1'b1, 1'b0); expect_main("ovl5", 0, 0, 1);
        step(1'b1, 1'b1); expect_main("ovl6", 1, 0, 1);
        step(1'b1, 1'b1); expect_main("ovl7", 1, 0, 1);
`endif

        // ---- Valid gaps: 3 idle cycles after each bit, din toggling/X ----
        pulse_reset("gap_rst");
        for (int i = 0; i < 4; i++) begin
            step(1'b1, pat[3-i]);
            expect_main($sformatf("gap_bit%0d", i), i + 1, (i == 3) ? 1 : 0, (i == 3) ? 1 : 0);
            step(1'b0, 1'b1);
            expect_main($sformatf("gap_a%0d", i), i + 1, 0, (i == 3) ? 1 : 0);
            step(1'b0, 1'bx);
            check($sformatf("gap_b%0d.state", i), 32'(state_o), 32'(i + 1));
            step(1'b0, ~pat[3-i]);
            check($sformatf("gap_c%0d.state", i), 32'(state_o), 32'(i + 1));
        end
        check("gap_end.cnt", 32'(det_cnt), 32'd1);

        // ---- Near-miss: 1,1,0,0,1,0,1,0,1,1 ----
        pulse_reset("near_rst");
        near = 10'b1100101011;
        path = '{1, 1, 2, 0, 1, 2, 3, 2, 3, 4};
        for (int i = 0; i < 10; i++) begin
            step(1'b1, near[9-i]);
            check($sformatf("near%0d.state", i), 32'(state_o), 32'(path[i]));
            check($sformatf("near%0d.det", i), 32'(det), (i == 9) ? 32'd1 : 32'd0);
        end
        check("near.cnt", 32'(det_cnt), 32'd1);

        // ---- Reset mid-stream, after "101" ----
        pulse_reset("mid_pre");
        step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b1);
        expect_main("mid_101", 3, 0, 0);
        pulse_reset("mid_rst");
        for (int i = 0; i < 4; i++) step(1'b1, pat[3-i]);
        expect_main("mid_after", 4, 1, 1);

        // ---- Reset while the det pulse is visible ----
        pulse_reset("pending_rst");

        // ---- Saturation on CNT_W=2: five back-to-back 1011 patterns ----
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b1);
            check($sformatf("sat%0d.pre_det", k), 32'(sat_det), 32'd0);
            step(1'b1, 1'b1);
            check($sformatf("sat%0d.det", k), 32'(sat_det), 32'd1);
            check($sformatf("sat%0d.cnt", k), 32'(sat_cnt), (k >= 2) ? 32'd3 : 32'(k + 1));
            check($sformatf("sat%0d.main_cnt", k), 32'(det_cnt), 32'(k + 1));
        end
        step(1'b0, 1'b0);
        check("sat_end.det", 32'(sat_det), 32'd0);
        check("sat_end.cnt", 32'(sat_cnt), 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
